alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Round-robin arbiter that shares one combinational 32-bit ALU between two requesters. Each requester presents operands and an ALUOp over a valid/ready handshake. The block forwards the winner's operation to the shared ALU and captures the result in that requester's response register. It sits between the two datapath clients and the single ALU instance, which stays purely combinational.

## Interface
- WIDTH, 32, operand and result width
- OP_W, 3, ALUOp width (0 add, 1 sub, 2 and, 3 or, 4 logical right shift, others arithmetic right shift; ALU-defined)
- CNT_W, 16, grant-counter width (used only with ALU_ARB_STATS_EN)

- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- req0_valid / req1_valid  in  1  request present
- req0_ready / req1_ready  out  1  request accepted this cycle (grant)
- req0_a, req0_b / req1_a, req1_b  in  WIDTH  operands
- req0_op / req1_op  in  OP_W  ALUOp
- rsp0_valid / rsp1_valid  out  1  result held
- rsp0_data / rsp1_data  out  WIDTH  result
- rsp0_ready / rsp1_ready  in  1  consumer takes result
- alu_a, alu_b  out  WIDTH  to shared ALU
- alu_op  out  OP_W  to shared ALU
- alu_c  in  WIDTH  from shared ALU (combinational)
- gnt0_cnt / gnt1_cnt  out  CNT_W  grant counters (ALU_ARB_STATS_EN only)

## Operation
- eligible[i] = req_i_valid & (~rsp_i_valid | rsp_i_ready). A full slot that is being drained this cycle counts as free.
- Exactly one grant per cycle at most:
  - only one eligible → grant it
  - both eligible → grant the one not granted last (`last` pointer)
- `last` updates only on a grant. Reset value 1, so requester 0 wins the first tie.
- req_i_ready = grant[i], combinational. req_ready never depends on req_ready.
- ALU mux:
  - grant[i] → alu_a/alu_b/alu_op = req_i fields
  - no grant → all zero
- Response register i:
  - on grant[i]: rsp_i_data <= alu_c, rsp_i_valid <= 1
  - else if rsp_i_valid & rsp_i_ready: rsp_i_valid <= 0; rsp_i_data holds
  - grant and drain in the same cycle: the new result replaces the old one and valid stays 1
- Results are full WIDTH with no flags. Overflow wraps mod 2^WIDTH, as the ALU produces it.
- A requester whose slot is full and not draining is not eligible. The other requester may still be granted.
- Reset mid-operation: all responses are dropped, `last` = 1, counters clear. A requester holding valid through reset is re-arbitrated from scratch.

## Timing
- Reset values:
  - req*_ready = 0 (combinational, valid low)
  - rsp*_valid = 0, rsp*_data = 0
  - alu_* = 0
  - gnt*_cnt = 0
- Latency: accept in cycle N → rsp_valid high and data visible from cycle N+1.
- Throughput: one operation per cycle total. A single requester with rsp_ready held high gets one result per cycle.
- Both requesters streaming with both rsp_ready high: grants alternate 0,1,0,1…
- Requesters must hold a/b/op stable while valid & ~ready. The arbiter does not check this.

## Configuration
- ALU_ARB_STATS_EN defined:
  - gnt0_cnt / gnt1_cnt increment by 1 on each grant to that requester and saturate at 2^CNT_W−1
  - cleared by reset
- ALU_ARB_STATS_EN undefined: counter ports and logic are absent; behaviour is otherwise identical.

## Test plan
- After reset release, req0 only, a=5, b=3, op=1, rsp0_ready=1 → req0_ready=1 in cycle N; rsp0_valid=1, rsp0_data=2 in N+1; rsp0_valid=0 in N+2.
- Both requesters valid continuously: req0 op=0 a=1 b=1, req1 op=5 a=0x80000000 b=4, both rsp_ready=1 → grant order 0,1,0,1. rsp1_data=0xF8000000, rsp0_data=2.
- req0 valid, rsp0_ready=0 after the first result (0xFFFFFFFF from op=1 a=0 b=1) → req0_ready stays 0 and rsp0_data holds 0xFFFFFFFF. Concurrent req1 (op=3 a=0xF0 b=0x0F) still granted, rsp1_data=0xFF.
- Slot full with rsp0_ready=1 and a new req0 (op=2 a=0xFF b=0x0F) in the same cycle → grant; rsp0_valid stays 1, data becomes 0x0F next cycle.
- Assert reset low mid-stream with rsp0_valid=1 → rsp0_valid=0 and rsp0_data=0 immediately (asynchronous). After release, the first tie goes to requester 0.
- With ALU_ARB_STATS_EN and CNT_W=4: 20 consecutive req0 grants → gnt0_cnt saturates at 15 and gnt1_cnt=0.

Source files
------------

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbiter sharing one combinational ALU between two
// requesters. Each requester owns a one-entry response register that holds
// the ALU result until its consumer takes it.
// Optional feature macro: ALU_ARB_STATS_EN adds saturating per-requester
// grant counters (gnt0_cnt / gnt1_cnt) sized by CNT_W.
module alu_arbiter #(
   parameter int WIDTH = 32,
   parameter int OP_W  = 3,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,

   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic [OP_W-1:0]  req0_op,

   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   input  logic [OP_W-1:0]  req1_op,

   output logic             rsp0_valid,
   output logic [WIDTH-1:0] rsp0_data,
   input  logic             rsp0_ready,

   output logic             rsp1_valid,
   output logic [WIDTH-1:0] rsp1_data,
   input  logic             rsp1_ready,

   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [OP_W-1:0]  alu_op,
   input  logic [WIDTH-1:0] alu_c
`ifdef ALU_ARB_STATS_EN
   ,
   output logic [CNT_W-1:0] gnt0_cnt,
   output logic [CNT_W-1:0] gnt1_cnt
`endif
);

   logic elig0;
   logic elig1;
   logic gnt0;
   logic gnt1;
   // last = 1 means requester 1 won the most recent grant, so 0 wins a tie
   logic last;

   // a slot being drained this cycle is free for a new result
   assign elig0 = req0_valid & (~rsp0_valid | rsp0_ready);
   assign elig1 = req1_valid & (~rsp1_valid | rsp1_ready);

   // pick at most one winner; ties go to whoever did not win last time
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (elig0 && elig1) begin
         if (last) begin
            gnt0 = 1'b1;
         end else begin
            gnt1 = 1'b1;
         end
      end else begin
         gnt0 = elig0;
         gnt1 = elig1;
      end
   end

   assign req0_ready = gnt0;
   assign req1_ready = gnt1;

   // steer the winner's operands to the shared ALU, zero when idle
   always_comb begin
      alu_a  = '0;
      alu_b  = '0;
      alu_op = '0;
      if (gnt0) begin
         alu_a  = req0_a;
         alu_b  = req0_b;
         alu_op = req0_op;
      end else if (gnt1) begin
         alu_a  = req1_a;
         alu_b  = req1_b;
         alu_op = req1_op;
      end
   end

   // round-robin pointer moves only when somebody is granted
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         last <= 1'b1;
      end else if (gnt0) begin
         last <= 1'b0;
      end else if (gnt1) begin
         last <= 1'b1;
      end
   end

   // response slot 0: capture on grant, release when the consumer takes it
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rsp0_valid <= 1'b0;
         rsp0_data  <= '0;
      end else if (gnt0) begin
         rsp0_valid <= 1'b1;
         rsp0_data  <= alu_c;
      end else if (rsp0_valid && rsp0_ready) begin
         rsp0_valid <= 1'b0;
      end
   end

   // response slot 1: capture on grant, release when the consumer takes it
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rsp1_valid <= 1'b0;
         rsp1_data  <= '0;
      end else if (gnt1) begin
         rsp1_valid <= 1'b1;
         rsp1_data  <= alu_c;
      end else if (rsp1_valid && rsp1_ready) begin
         rsp1_valid <= 1'b0;
      end
   end

`ifdef ALU_ARB_STATS_EN
   // grant counters stick at all-ones instead of wrapping
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         gnt0_cnt <= '0;
         gnt1_cnt <= '0;
      end else begin
         if (gnt0 && (gnt0_cnt != '1)) begin
            gnt0_cnt <= gnt0_cnt + CNT_W'(1);
         end
         if (gnt1 && (gnt1_cnt != '1)) begin
            gnt1_cnt <= gnt1_cnt + CNT_W'(1);
         end
      end
   end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed plus randomized bench for alu_arbiter. The bench
// plays the role of the shared ALU and keeps a slot-level reference model of
// both response registers, the round-robin winner and the grant counters.
`timescale 1ns/1ps
module tb_alu_arbiter;

   localparam int WIDTH = 32;
   localparam int OP_W  = 3;
   localparam int CNT_W = 4;

   logic             clk = 1'b0;
   logic             reset;
   logic             req0_valid, req1_valid;
   logic             req0_ready, req1_ready;
   logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
   logic [OP_W-1:0]  req0_op, req1_op;
   logic             rsp0_valid, rsp1_valid;
   logic [WIDTH-1:0] rsp0_data, rsp1_data;
   logic             rsp0_ready, rsp1_ready;
   logic [WIDTH-1:0] alu_a, alu_b, alu_c;
   logic [OP_W-1:0]  alu_op;
`ifdef ALU_ARB_STATS_EN
   logic [CNT_W-1:0] gnt0_cnt, gnt1_cnt;
`endif

   int checks   = 0;
   int failures = 0;

   // reference model state
   logic             slotFull [2];
   logic [WIDTH-1:0] slotData [2];
   int               lastWinner;
   int               grantCount [2];
   int               lastGrant;

   alu_arbiter #(.WIDTH(WIDTH), .OP_W(OP_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req0_ready(req0_ready),
      .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
      .req1_valid(req1_valid), .req1_ready(req1_ready),
      .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
      .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data), .rsp0_ready(rsp0_ready),
      .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data), .rsp1_ready(rsp1_ready),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_c(alu_c)
`ifdef ALU_ARB_STATS_EN
      , .gnt0_cnt(gnt0_cnt), .gnt1_cnt(gnt1_cnt)
`endif
   );

   always #5 clk = ~clk;

   // arithmetic meaning of each ALUOp
   function automatic logic [WIDTH-1:0] aluRef(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b,
                                               input logic [OP_W-1:0]  op);
      case (op)
         3'd0:    return a + b;
         3'd1:    return a - b;
         3'd2:    return a & b;
         3'd3:    return a | b;
         3'd4:    return a >> b;
         default: return WIDTH'($signed(a) >>> b);
      endcase
   endfunction

   // the bench acts as the shared combinational ALU
   always_comb alu_c = aluRef(alu_a, alu_b, alu_op);

   function automatic logic [WIDTH-1:0] pickOperand();
      case ($urandom_range(0, 5))
         0:       return 32'h0000_0000;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return 32'(32'($urandom_range(0, 40)));
         default: return 32'($urandom);
      endcase
   endfunction

   task automatic checkOutput(input string tag, input logic [WIDTH-1:0] observed,
                              input logic [WIDTH-1:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         failures++;
         $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
      end
   endtask

   task automatic resetModel();
      slotFull[0]   = 1'b0;
      slotFull[1]   = 1'b0;
      slotData[0]   = '0;
      slotData[1]   = '0;
      lastWinner    = 1;
      grantCount[0] = 0;
      grantCount[1] = 0;
      lastGrant     = -1;
   endtask

   task automatic applyStimulus(input logic v0, input logic [WIDTH-1:0] a0,
                                input logic [WIDTH-1:0] b0, input logic [OP_W-1:0] op0,
                                input logic rr0,
                                input logic v1, input logic [WIDTH-1:0] a1,
                                input logic [WIDTH-1:0] b1, input logic [OP_W-1:0] op1,
                                input logic rr1);
      req0_valid = v0; req0_a = a0; req0_b = b0; req0_op = op0; rsp0_ready = rr0;
      req1_valid = v1; req1_a = a1; req1_b = b1; req1_op = op1; rsp1_ready = rr1;
   endtask

   // check the combinational grant, clock once, then check the response slots
   task automatic runCycle(input string tag);
      logic             vld [2];
      logic             rr  [2];
      logic             elig [2];
      logic [WIDTH-1:0] ra [2];
      logic [WIDTH-1:0] rb [2];
      logic [OP_W-1:0]  rop [2];
      int               want;
      #1;
      vld[0] = req0_valid; rr[0] = rsp0_ready; ra[0] = req0_a; rb[0] = req0_b; rop[0] = req0_op;
      vld[1] = req1_valid; rr[1] = rsp1_ready; ra[1] = req1_a; rb[1] = req1_b; rop[1] = req1_op;
      for (int i = 0; i < 2; i++) elig[i] = vld[i] && (!slotFull[i] || rr[i]);
      want = -1;
      if (elig[0] && elig[1]) want = 1 - lastWinner;
      else if (elig[0])       want = 0;
      else if (elig[1])       want = 1;
      checkOutput({tag, "/req0_ready"}, 32'(req0_ready), 32'(want == 0));
      checkOutput({tag, "/req1_ready"}, 32'(req1_ready), 32'(want == 1));
      checkOutput({tag, "/alu_a"}, alu_a, (want < 0) ? '0 : ra[want]);
      checkOutput({tag, "/alu_b"}, alu_b, (want < 0) ? '0 : rb[want]);
      checkOutput({tag, "/alu_op"}, 32'(alu_op), (want < 0) ? '0 : 32'(rop[want]));
      @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
         if (i == want) begin
            slotFull[i] = 1'b1;
            slotData[i] = aluRef(ra[i], rb[i], rop[i]);
            lastWinner  = i;
`ifdef ALU_ARB_STATS_EN
            if (grantCount[i] < (1 << CNT_W) - 1) grantCount[i]++;
`endif
         end else if (slotFull[i] && rr[i]) begin
            slotFull[i] = 1'b0;
         end
      end
      lastGrant = want;
      checkOutput({tag, "/rsp0_valid"}, 32'(rsp0_valid), 32'(slotFull[0]));
      checkOutput({tag, "/rsp0_data"}, rsp0_data, slotData[0]);
      checkOutput({tag, "/rsp1_valid"}, 32'(rsp1_valid), 32'(slotFull[1]));
      checkOutput({tag, "/rsp1_data"}, rsp1_data, slotData[1]);
`ifdef ALU_ARB_STATS_EN
      checkOutput({tag, "/gnt0_cnt"}, 32'(gnt0_cnt), 32'(grantCount[0]));
      checkOutput({tag, "/gnt1_cnt"}, 32'(gnt1_cnt), 32'(grantCount[1]));
`endif
   endtask

   // directed scenarios from the test plan followed by randomized traffic
   initial begin
      logic             hold [2];
      logic             rv [2];
      logic             rrr [2];
      logic [WIDTH-1:0] sa [2];
      logic [WIDTH-1:0] sb [2];
      logic [OP_W-1:0]  sop [2];

      reset = 1'b0;
      applyStimulus(0, '0, '0, '0, 0, 0, '0, '0, '0, 0);
      resetModel();
      #2;
      checkOutput("reset/req0_ready", 32'(req0_ready), 32'd0);
      checkOutput("reset/req1_ready", 32'(req1_ready), 32'd0);
      checkOutput("reset/rsp0_valid", 32'(rsp0_valid), 32'd0);
      checkOutput("reset/rsp1_valid", 32'(rsp1_valid), 32'd0);
      checkOutput("reset/rsp0_data", rsp0_data, 32'd0);
      checkOutput("reset/rsp1_data", rsp1_data, 32'd0);
      checkOutput("reset/alu_a", alu_a, 32'd0);
`ifdef ALU_ARB_STATS_EN
      checkOutput("reset/gnt0_cnt", 32'(gnt0_cnt), 32'd0);
`endif
      @(posedge clk);
      #1;
      reset = 1'b1;

      applyStimulus(1, 32'd5, 32'd3, 3'd1, 1, 0, '0, '0, '0, 1);
      #1 checkOutput("t1/grant", 32'(req0_ready), 32'd1);
      runCycle("t1a");
      checkOutput("t1/rsp0_data", rsp0_data, 32'd2);
      checkOutput("t1/rsp0_valid", 32'(rsp0_valid), 32'd1);
      applyStimulus(0, '0, '0, '0, 1, 0, '0, '0, '0, 1);
      runCycle("t1b");
      checkOutput("t1/rsp0_drained", 32'(rsp0_valid), 32'd0);

      applyStimulus(1, 32'd0, 32'd1, 3'd1, 0, 0, '0, '0, '0, 0);
      runCycle("t3a");
      checkOutput("t3/rsp0_first", rsp0_data, 32'hFFFF_FFFF);
      applyStimulus(1, 32'd0, 32'd1, 3'd1, 0, 1, 32'hF0, 32'h0F, 3'd3, 0);
      #1;
      checkOutput("t3/req0_blocked", 32'(req0_ready), 32'd0);
      checkOutput("t3/req1_granted", 32'(req1_ready), 32'd1);
      runCycle("t3b");
      checkOutput("t3/rsp0_hold", rsp0_data, 32'hFFFF_FFFF);
      checkOutput("t3/rsp1_data", rsp1_data, 32'h0000_00FF);
      applyStimulus(1, 32'd0, 32'd1, 3'd1, 0, 0, '0, '0, '0, 1);
      runCycle("t3c");

      applyStimulus(1, 32'hFF, 32'h0F, 3'd2, 1, 0, '0, '0, '0, 1);
      runCycle("t4");
      checkOutput("t4/rsp0_valid", 32'(rsp0_valid), 32'd1);
      checkOutput("t4/rsp0_data", rsp0_data, 32'h0000_000F);

      applyStimulus(0, '0, '0, '0, 0, 0, '0, '0, '0, 0);
      reset = 1'b0;
      #1;
      checkOutput("t5/rsp0_valid", 32'(rsp0_valid), 32'd0);
      checkOutput("t5/rsp0_data", rsp0_data, 32'd0);
      resetModel();
      @(posedge clk);
      #1;
      reset = 1'b1;

      applyStimulus(1, 32'd1, 32'd1, 3'd0, 1, 1, 32'h8000_0000, 32'd4, 3'd5, 1);
      for (int k = 0; k < 4; k++) begin
         #1 checkOutput("t2/order", 32'(req1_ready), 32'(k % 2));
         runCycle("t2");
         if (k == 0) checkOutput("t2/rsp0_data", rsp0_data, 32'd2);
         if (k == 1) checkOutput("t2/rsp1_data", rsp1_data, 32'hF800_0000);
      end

      hold[0] = 1'b0;
      hold[1] = 1'b0;
      for (int n = 0; n < 400; n++) begin
         for (int i = 0; i < 2; i++) begin
            if (!hold[i]) begin
               rv[i]  = ($urandom_range(0, 3) != 0);
               sa[i]  = pickOperand();
               sb[i]  = pickOperand();
               sop[i] = OP_W'($urandom_range(0, 7));
            end
            rrr[i] = ($urandom_range(0, 2) != 0);
         end
         applyStimulus(rv[0], sa[0], sb[0], sop[0], rrr[0],
                       rv[1], sa[1], sb[1], sop[1], rrr[1]);
         runCycle("rand");
         for (int i = 0; i < 2; i++) hold[i] = rv[i] && (lastGrant != i);
      end

`ifdef ALU_ARB_STATS_EN
      applyStimulus(0, '0, '0, '0, 0, 0, '0, '0, '0, 0);
      reset = 1'b0;
      resetModel();
      @(posedge clk);
      #1;
      reset = 1'b1;
      for (int k = 0; k < 20; k++) begin
         applyStimulus(1, 32'(k), 32'd1, 3'd0, 1, 0, '0, '0, '0, 1);
         runCycle("stats");
      end
      checkOutput("stats/gnt0_sat", 32'(gnt0_cnt), 32'd15);
      checkOutput("stats/gnt1_zero", 32'(gnt1_cnt), 32'd0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
